// File: rtl/mem_stage.sv
// mem_stage: EX->MEM stage register, data-memory request FSM and load alignment.
// Defining MEM_ALIGN_CHECK_EN adds a misaligned-access trap and the ale_o port.
module mem_stage (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic [107:0]   ex2mem_bus_i,
  input  logic           ex_over_i,
  output logic           mem_allowin_o,
  output logic [69:0]    mem2wb_bus_o,
  output logic           mem_over_o,
  input  logic           wb_allowin_i,
  output logic [4:0]     mem_dest_o,
  output logic [31:0]    mem_pc_o,
  output logic           data_req_o,
  output logic           data_wr_o,
  output logic [1:0]     data_size_o,
  output logic [31:0]    data_addr_o,
  output logic [3:0]     data_wstrb_o,
  output logic [31:0]    data_wdata_o,
  input  logic           data_addr_ok_i,
  input  logic           data_data_ok_i,
  input  logic [31:0]    data_rdata_i
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic           ale_o
`endif
);
  localparam int EX2MEMBusSize = 108;
  localparam int MEM2WBBusSize = 70;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_valid;
  logic [EX2MEMBusSize-1:0] r_bus;
  logic [31:0]              r_ld_data;

  logic        w_is_load, w_is_store, w_uns, w_we, w_mis, w_in_mis, w_in_mem;
  logic        w_latch, w_leave, w_req, w_capture, w_we_eff, w_unused;
  logic [1:0]  w_size;
  logic [31:0] w_st, w_exe, w_pc, w_wb_result;
  logic [4:0]  w_rd;

  // Size code 3 is undefined and is handled as a word access.
  function automatic logic [1:0] f_size(input logic [1:0] s);
    return (s == 2'd3) ? 2'd2 : s;
  endfunction

  function automatic logic [3:0] f_wstrb(input logic [1:0] s, input logic [1:0] a);
    case (s)
      2'd0:    return 4'b0001 << a;
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] s, input logic [31:0] st);
    case (s)
      2'd0:    return {4{st[7:0]}};
      2'd1:    return {2{st[15:0]}};
      default: return st;
    endcase
  endfunction

  function automatic logic [31:0] f_load_align(input logic [31:0] rd, input logic [1:0] a,
                                               input logic [1:0] s, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (s)
      2'd0:    return uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return rd;
    endcase
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  function automatic logic f_misaligned(input logic [1:0] s, input logic [1:0] a);
    case (s)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      default: return a != 2'd0;
    endcase
  endfunction
`endif

  assign w_is_load  = r_bus[107];
  assign w_is_store = r_bus[106] & ~r_bus[107];
  assign w_size     = f_size(r_bus[105:104]);
  assign w_uns      = r_bus[103];
  assign w_unused   = r_bus[102];
  assign w_st       = r_bus[101:70];
  assign w_exe      = r_bus[69:38];
  assign w_rd       = r_bus[37:33];
  assign w_we       = r_bus[32];
  assign w_pc       = r_bus[31:0];
  assign w_in_mem   = ex2mem_bus_i[107] | ex2mem_bus_i[106];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_in_mis = w_in_mem & f_misaligned(f_size(ex2mem_bus_i[105:104]), ex2mem_bus_i[39:38]);
  assign w_mis    = (w_is_load | w_is_store) & f_misaligned(w_size, w_exe[1:0]);
  assign ale_o    = r_valid & w_mis;
`else
  assign w_in_mis = 1'b0;
  assign w_mis    = 1'b0;
`endif

  assign mem_over_o    = r_valid & (r_state == S_DONE);
  assign w_leave       = mem_over_o & wb_allowin_i;
  assign mem_allowin_o = ~r_valid | w_leave;
  assign w_latch       = ex_over_i & mem_allowin_o;
  assign w_req         = (r_state == S_REQ);
  assign w_capture     = w_is_load & data_data_ok_i &
                         ((w_req & data_addr_ok_i) | (r_state == S_WAIT));

  // Stage register: a new latch takes priority over the departure of the old instruction.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_valid <= 1'b0;
      r_bus   <= {EX2MEMBusSize{1'b0}};
    end else if (w_latch) begin
      r_valid <= 1'b1;
      r_bus   <= ex2mem_bus_i;
    end else if (w_leave) begin
      r_valid <= 1'b0;
    end
  end

  // Memory-access state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state: data_ok is only honoured while a request is outstanding.
  always_comb begin
    w_state_nxt = r_state;
    if (w_latch) begin
      if (w_in_mem & ~w_in_mis) w_state_nxt = S_REQ;
      else                      w_state_nxt = S_DONE;
    end else begin
      case (r_state)
        S_REQ: begin
          if (data_addr_ok_i) w_state_nxt = data_data_ok_i ? S_DONE : S_WAIT;
          else                w_state_nxt = S_REQ;
        end
        S_WAIT:  w_state_nxt = data_data_ok_i ? S_DONE : S_WAIT;
        S_DONE:  w_state_nxt = w_leave ? S_IDLE : S_DONE;
        S_IDLE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Aligned/extended load data, captured on the cycle the read data returns.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)        r_ld_data <= 32'd0;
    else if (w_capture) r_ld_data <= f_load_align(data_rdata_i, w_exe[1:0], w_size, w_uns);
  end

  assign data_req_o   = w_req;
  assign data_wr_o    = w_req & w_is_store;
  assign data_size_o  = w_req ? w_size : 2'd0;
  assign data_addr_o  = w_req ? w_exe : 32'd0;
  assign data_wstrb_o = (w_req & w_is_store) ? f_wstrb(w_size, w_exe[1:0]) : 4'd0;
  assign data_wdata_o = (w_req & w_is_store) ? f_wdata(w_size, w_st) : 32'd0;

  assign w_we_eff     = w_we & ~w_mis;
  assign w_wb_result  = w_mis ? 32'd0 : (w_is_load ? r_ld_data : w_exe);
  assign mem2wb_bus_o = {w_wb_result, w_rd, w_we_eff, w_pc};
  assign mem_dest_o   = (r_valid & w_we_eff) ? w_rd : 5'd0;
  assign mem_pc_o     = w_pc;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios, then random traffic checked against a
// byte-addressed memory model and in-order expectation queues.
module tb_mem_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn, ex_over, allowin, over, wb_allow, req, wr, addr_ok, data_ok;
  logic [107:0] ex_bus;
  logic [69:0]  wb_bus;
  logic [4:0]   dest;
  logic [31:0]  mpc, addr, wdata, rdata;
  logic [1:0]   size;
  logic [3:0]   wstrb;
  logic         ale;

  mem_stage dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .ex2mem_bus_i(ex_bus),
    .ex_over_i(ex_over),
    .mem_allowin_o(allowin),
    .mem2wb_bus_o(wb_bus),
    .mem_over_o(over),
    .wb_allowin_i(wb_allow),
    .mem_dest_o(dest),
    .mem_pc_o(mpc),
    .data_req_o(req),
    .data_wr_o(wr),
    .data_size_o(size),
    .data_addr_o(addr),
    .data_wstrb_o(wstrb),
    .data_wdata_o(wdata),
    .data_addr_ok_i(addr_ok),
    .data_data_ok_i(data_ok),
`ifdef MEM_ALIGN_CHECK_EN
    .ale_o(ale),
`endif
    .data_rdata_i(rdata)
  );

`ifndef MEM_ALIGN_CHECK_EN
  assign ale = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [69:0] wq[$];
  logic        aleq[$];
  req_t        rq[$];
  logic [7:0]  gmem[64];
  logic [31:0] rmem[16];
  bit          pend = 1'b0;
  int          pend_cnt;
  logic [31:0] p_addr, p_wdata;
  logic        p_wr;
  logic [3:0]  p_strb;

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [107:0] mk(input logic [5:0] ctl, input logic [31:0] st,
                                      input logic [31:0] exe, input logic [4:0] rd,
                                      input logic we, input logic [31:0] pc);
    return {ctl, st, exe, rd, we, pc};
  endfunction

  function automatic logic [107:0] rand_instr();
    int k;
    logic [1:0] ls;
    k  = $urandom_range(0, 7);
    ls = (k < 3) ? 2'b00 : (k < 5) ? 2'b10 : (k < 7) ? 2'b01 : 2'b11;
    return mk({ls, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 3))}, $urandom, $urandom,
              5'($urandom), 1'($urandom), $urandom);
  endfunction

  // Reference: memory seen as bytes; an access covers nb bytes from the access-aligned base.
  task automatic model_latch(input logic [107:0] b);
    logic [5:0]  c;
    logic [31:0] st, a, v;
    logic        ld, sto, we, mis;
    int          nb, base;
    req_t        r;
    c = b[107:102]; st = b[101:70]; a = b[69:38]; we = b[32];
    ld  = c[5];
    sto = c[4] & ~c[5];
    nb  = 1 << c[3:2];
    base = (int'(a[5:0]) / nb) * nb;
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (ld | sto) && ((int'(a[1:0]) % nb) != 0);
`endif
    v = a;
    r.addr = a; r.wr = sto; r.size = c[3:2]; r.wstrb = 4'd0; r.wdata = 32'd0;
    if (mis) begin
      v = 32'd0;
      we = 1'b0;
    end else if (ld) begin
      v = 32'd0;
      for (int k = 0; k < nb; k++) v = v | (32'(gmem[base + k]) << (8 * k));
      if (!c[1] && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      rq.push_back(r);
    end else if (sto) begin
      for (int k = 0; k < nb; k++) begin
        gmem[base + k] = st[8 * k +: 8];
        r.wstrb[(base + k) % 4] = 1'b1;
      end
      for (int l = 0; l < 4; l++) r.wdata[8 * l +: 8] = st[8 * (l % nb) +: 8];
      rq.push_back(r);
    end
    wq.push_back({v, b[37:33], we, b[31:0]});
    aleq.push_back(mis);
  endtask

  task automatic fire();
    data_ok = 1'b1;
    pend = 1'b0;
    if (p_wr) begin
      for (int l = 0; l < 4; l++)
        if (p_strb[l]) rmem[p_addr[5:2]][8 * l +: 8] = p_wdata[8 * l +: 8];
    end else begin
      rdata = rmem[p_addr[5:2]];
    end
  endtask

  // One clock of random traffic: check held request, drive inputs, then score handshakes.
  task automatic cycle(input bit gen);
    req_t r;
    bit   ret, lat, acc;
    @(negedge clk);
    if (req) begin
      if (rq.size() == 0) chk("spurious_req", 70'(req), 70'd0);
      else begin
        r = rq[0];
        chk("req_addr", 70'(addr), 70'(r.addr));
        chk("req_wr", 70'(wr), 70'(r.wr));
        chk("req_size", 70'(size), 70'(r.size));
        if (r.wr) begin
          chk("req_wstrb", 70'(wstrb), 70'(r.wstrb));
          chk("req_wdata", 70'(wdata), 70'(r.wdata));
        end
      end
    end
    wb_allow = !gen || ($urandom_range(0, 3) != 0);
    ex_over  = gen && ($urandom_range(0, 1) == 1);
    ex_bus   = rand_instr();
    addr_ok  = 1'b0;
    data_ok  = 1'b0;
    rdata    = $urandom;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) fire();
    end else if (req) begin
      addr_ok = 1'($urandom_range(0, 1));
      if (addr_ok) begin
        p_addr = addr; p_wr = wr; p_strb = wstrb; p_wdata = wdata;
        pend = 1'b1;
        pend_cnt = $urandom_range(0, 2);
        if (pend_cnt == 0) fire();
      end
    end else if ($urandom_range(0, 9) == 0) begin
      data_ok = 1'b1;
    end
    #1;
    if (!wb_allow) chk("allowin_hold", 70'(allowin), 70'(wq.size() == 0));
    if (wq.size() == 0) chk("over_empty", 70'(over), 70'd0);
    ret = over & wb_allow;
    lat = ex_over & allowin;
    acc = req & addr_ok;
    if (ret && wq.size() != 0) begin
      chk("wb_bus", wb_bus, wq[0]);
      chk("wb_dest", 70'(dest), wq[0][32] ? 70'(wq[0][37:33]) : 70'd0);
      chk("wb_pc", 70'(mpc), 70'(wq[0][31:0]));
      chk("wb_ale", 70'(ale), 70'(aleq[0]));
      void'(wq.pop_front());
      void'(aleq.pop_front());
    end
    if (acc && rq.size() != 0) void'(rq.pop_front());
    if (lat) model_latch(ex_bus);
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_over"}, 70'(over), 70'd0);
    chk({tag, "_bus"}, wb_bus, 70'd0);
    chk({tag, "_req"}, 70'({req, wr, size, wstrb}), 70'd0);
    chk({tag, "_addr"}, 70'({addr, wdata}), 70'd0);
    chk({tag, "_dest_pc"}, 70'({dest, mpc}), 70'd0);
  endtask

  task automatic byte_load(input logic uns, input logic [31:0] exp);
    @(negedge clk);
    ex_bus = mk({1'b1, 1'b0, 2'd0, uns, 1'b0}, 32'd0, 32'h0000_1003, 5'd3, 1'b1, 32'h100);
    ex_over = 1'b1; wb_allow = 1'b1;
    @(negedge clk);
    ex_over = 1'b0;
    chk("ld_req", 70'({req, wr, size}), 70'({1'b1, 1'b0, 2'd0}));
    chk("ld_addr", 70'(addr), 70'h1003);
    addr_ok = 1'b1;
    @(negedge clk);
    addr_ok = 1'b0;
    chk("ld_wait", 70'({req, over}), 70'd0);
    data_ok = 1'b1; rdata = 32'h80FF_FFFF;
    @(negedge clk);
    data_ok = 1'b0; rdata = 32'd0;
    chk("ld_over", 70'(over), 70'd1);
    chk("ld_result", 70'(wb_bus[69:38]), 70'(exp));
    @(negedge clk);
    chk("ld_left", 70'(over), 70'd0);
  endtask

  initial begin
    rstn = 1'b1; ex_over = 1'b0; ex_bus = '0; wb_allow = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'd0;
    #2 rstn = 1'b0;
    @(negedge clk);
    chk("rst_allowin", 70'(allowin), 70'd1);
    zero_check("rst");
    rstn = 1'b1;

    // ALU op retires one cycle after latch.
    @(negedge clk);
    ex_bus = mk(6'd0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd7, 1'b1, 32'h40);
    ex_over = 1'b1; wb_allow = 1'b1;
    @(negedge clk);
    ex_over = 1'b0;
    chk("alu_over", 70'(over), 70'd1);
    chk("alu_result", 70'(wb_bus[69:38]), 70'h1234_5678);
    chk("alu_dest", 70'(dest), 70'd7);
    chk("alu_req", 70'(req), 70'd0);
    @(negedge clk);
    chk("alu_left", 70'({over, allowin}), 70'b01);

    byte_load(1'b0, 32'hFFFF_FF80);
    byte_load(1'b1, 32'h0000_0080);

    // Half store at offset 2 with WB stalled after completion.
    @(negedge clk);
    ex_bus = mk({2'b01, 2'd1, 2'b00}, 32'h0000_ABCD, 32'h0000_2002, 5'd0, 1'b0, 32'h200);
    ex_over = 1'b1; wb_allow = 1'b0;
    @(negedge clk);
    ex_over = 1'b0;
    chk("st_req", 70'({req, wr, size}), 70'({1'b1, 1'b1, 2'd1}));
    chk("st_wstrb", 70'(wstrb), 70'b1100);
    chk("st_wdata", 70'(wdata), 70'hABCD_ABCD);
    addr_ok = 1'b1;
    @(negedge clk);
    addr_ok = 1'b0;
    chk("st_wait", 70'({over, allowin}), 70'd0);
    data_ok = 1'b1; rdata = 32'h5555_5555;
    @(negedge clk);
    data_ok = 1'b0;
    chk("st_done", 70'({over, allowin}), 70'b10);
    chk("st_result", wb_bus, {32'h0000_2002, 5'd0, 1'b0, 32'h200});
    wb_allow = 1'b1;
    @(negedge clk);
    chk("st_left", 70'(over), 70'd0);

    // Reset while waiting for data; the late data_ok must be ignored.
    @(negedge clk);
    ex_bus = mk({2'b10, 2'd2, 2'b00}, 32'd0, 32'h0000_3000, 5'd9, 1'b1, 32'h300);
    ex_over = 1'b1;
    @(negedge clk);
    ex_over = 1'b0; addr_ok = 1'b1;
    @(negedge clk);
    addr_ok = 1'b0; rstn = 1'b0;
    #1 zero_check("rst_wait");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    data_ok = 1'b1; rdata = 32'hCAFE_F00D;
    @(negedge clk);
    data_ok = 1'b0;
    zero_check("late_ok");

    for (int i = 0; i < 16; i++) begin
      rmem[i] = $urandom;
      for (int k = 0; k < 4; k++) gmem[4 * i + k] = rmem[i][8 * k +: 8];
    end
    for (int c = 0; c < 4000; c++) cycle(1'b1);
    for (int c = 0; c < 60; c++) cycle(1'b0);
    chk("drain_wq", 70'(wq.size()), 70'd0);
    chk("drain_rq", 70'(rq.size()), 70'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage that sits directly downstream of the execute stage and upstream of write-back. It registers the EX→MEM bus under a valid/allow-in handshake, drives a request/response data-memory interface for loads and stores, and aligns and extends load data. It then presents the MEM→WB bus together with hazard-control signals.

## Interface
- `EX2MEMBusSize`, 108: input bus width, `{mem_ctl[5:0], st_data[31:0], exe_result[31:0], rd_addr[4:0], rd_we, pc[31:0]}`, MSB first.
- `MEM2WBBusSize`, 70: output bus width, `{wb_result[31:0], rd_addr[4:0], rd_we, pc[31:0]}`.
- `clk_i` in 1: clock.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `ex2mem_bus_i` in `EX2MEMBusSize`: EX result bus.
- `ex_over_i` in 1: EX has a finished instruction on `ex2mem_bus_i`.
- `mem_allowin_o` out 1: MEM accepts an instruction this cycle.
- `mem2wb_bus_o` out `MEM2WBBusSize`: registered-stage output to WB.
- `mem_over_o` out 1: MEM instruction complete; `mem2wb_bus_o` is valid.
- `wb_allowin_i` in 1: WB accepts this cycle.
- `mem_dest_o` out 5: `rd_addr` when valid and `rd_we`, else 0.
- `mem_pc_o` out 32: PC of the held instruction.
- `data_req_o` out 1: memory request.
- `data_wr_o` out 1: 1 = store.
- `data_size_o` out 2: 0 = byte, 1 = half, 2 = word.
- `data_addr_o` out 32: `exe_result`.
- `data_wstrb_o` out 4: byte write enables.
- `data_wdata_o` out 32: store data.
- `data_addr_ok_i` in 1: request accepted.
- `data_data_ok_i` in 1: read data or write acknowledge returned.
- `data_rdata_i` in 32: read data.
- `ale_o` out 1: misaligned-access flag. Present only with the configuration macro; see Configuration.

## Operation
- `mem_ctl` fields: [5] load, [4] store, [3:2] size, [1] unsigned load, [0] reserved (ignored). Load and store both set is illegal; treat it as a load.
- Stage register:
  - `mem_allowin_o = ~valid | (mem_over_o & wb_allowin_i)`.
  - On `ex_over_i & mem_allowin_o`: latch the bus and set `valid` = 1.
  - Else on `mem_over_o & wb_allowin_i`: clear `valid`.
- FSM states:
  - IDLE: no memory op in flight.
  - REQ: `data_req_o` = 1.
  - WAIT: request accepted, awaiting `data_data_ok_i`.
  - DONE: result held.
- FSM transitions:
  - Latching a load/store sets state REQ.
  - Latching a non-memory op sets state DONE.
  - REQ→WAIT on `data_addr_ok_i`.
  - WAIT→DONE on `data_data_ok_i`. For loads, capture the aligned data in this cycle.
  - DONE→IDLE when the instruction leaves, unless a new one is latched in the same cycle; that latch has priority.
- `mem_over_o = valid & (state == DONE)`.
- `data_req_o`, `data_wr_o`, `data_size_o`, `data_addr_o`, `data_wstrb_o` and `data_wdata_o` are held stable while in REQ. `data_req_o` = 0 in every other state.
- Store data:
  - byte: `{4{st[7:0]}}`, `wstrb = 4'b0001 << addr[1:0]`.
  - half: `{2{st[15:0]}}`, `wstrb = addr[1] ? 4'b1100 : 4'b0011`.
  - word: `st`, `wstrb = 4'hF`.
- Loads:
  - byte: select the lane by `addr[1:0]`.
  - half: select the lane by `addr[1]`.
  - Sign-extend unless `unsigned` = 1, which zero-extends.
- `wb_result` = captured load data for loads, else `exe_result`. Stores pass `exe_result` through; their `rd_we` is 0 from ID.
- The `data_ok` for a store is a write acknowledge only; `data_rdata_i` is ignored.

## Timing
- Reset values: `valid` = 0, state IDLE, every output 0, `mem_allowin_o` = 1.
- Latency from latch:
  - Non-memory op: `mem_over_o` in the next cycle (1 cycle).
  - Load/store with immediate `addr_ok` and `data_ok` one cycle later: `mem_over_o` 3 cycles after latch.
- WB back-pressure: DONE holds the bus and `mem_over_o` indefinitely; `mem_allowin_o` = 0.
- `addr_ok` and `data_ok` in the same cycle while in REQ: go directly to DONE and capture data.
- `data_ok` is never expected outside WAIT; ignore it there.
- Reset mid-transaction: everything clears immediately. Any later `data_ok` for the abandoned request is ignored, because the state is IDLE.
- Back-to-back: a new latch in the cycle the old instruction leaves produces no bubble.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Misaligned means a half access with `addr[0]` = 1, or a word access with `addr[1:0]` ≠ 0.
  - A misaligned load/store goes straight to DONE and issues no request.
  - `wb_result` = 0, `rd_we` is forced to 0, and `ale_o = valid & misaligned`.
- `MEM_ALIGN_CHECK_EN` undefined:
  - No `ale_o` port and no check.
  - The access issues with strobes and lane selection exactly as in Operation; ignored low address bits are dropped.

## Test plan
- ALU op, `exe_result` = 0x12345678, `wb_allowin` = 1 → `mem_over_o` 1 cycle after latch, `wb_result` = 0x12345678, `mem_dest_o` = `rd_addr`.
- Signed byte load at addr 0x...3, rdata = 0x80FFFFFF → `wb_result` = 0xFFFFFF80. The unsigned variant gives 0x00000080.
- Half store at addr 0x...2, st = 0xABCD → `wstrb` = 0b1100, `wdata` = 0xABCDABCD, `data_wr_o` = 1. `mem_over_o` only after `data_ok`.
- `addr_ok` delayed 3 cycles and `wb_allowin` = 0 for 2 cycles after DONE → request fields stay stable during the delay, `mem_allowin_o` = 0 throughout, no instruction is lost or duplicated.
- Reset asserted in WAIT, then `data_ok` pulses after release → all outputs stay 0, with no spurious `mem_over_o`.
- With `MEM_ALIGN_CHECK_EN`: word load at 0x...2 → no `data_req_o`, `ale_o` = 1 with `mem_over_o`, `rd_we` = 0.
